alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_comb.sv | 41 ++++
 rtl/alu_core.sv | 46 ++++
 tb/tb_alu_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU select encodings and widths, used by the datapath, the result register and the bench.
package alu_pkg;

   localparam int unsigned SEL_W = 4;

   localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [SEL_W-1:0] ALU_SUB  = 4'b1000;
   localparam logic [SEL_W-1:0] ALU_SLL  = 4'b0001;
   localparam logic [SEL_W-1:0] ALU_SLT  = 4'b0010;
   localparam logic [SEL_W-1:0] ALU_SLTU = 4'b0011;
   localparam logic [SEL_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [SEL_W-1:0] ALU_SRL  = 4'b0101;
   localparam logic [SEL_W-1:0] ALU_SRA  = 4'b1101;
   localparam logic [SEL_W-1:0] ALU_OR   = 4'b0110;
   localparam logic [SEL_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [SEL_W-1:0] ALU_LUI  = 4'b1001;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU datapath; unused select codes yield zero.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [SEL_W-1:0]  alusel_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int unsigned ShW = $clog2(DATA_W);

   logic [ShW-1:0] shamt;
   logic           lt_s;
   logic           lt_u;

   assign shamt = data2_i[ShW-1:0];
   assign lt_s  = $signed(data1_i) < $signed(data2_i);
   assign lt_u  = data1_i < data2_i;

   always_comb begin
      result_o = '0;
      case (alusel_i)
         ALU_ADD:  result_o = data1_i + data2_i;
         ALU_SUB:  result_o = data1_i - data2_i;
         ALU_SLL:  result_o = data1_i << shamt;
         ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, lt_s};
         ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, lt_u};
         ALU_XOR:  result_o = data1_i ^ data2_i;
         ALU_SRL:  result_o = data1_i >> shamt;
         ALU_SRA:  result_o = $signed(data1_i) >>> shamt;
         ALU_OR:   result_o = data1_i | data2_i;
         ALU_AND:  result_o = data1_i & data2_i;
         ALU_LUI:  result_o = data2_i;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_core.sv
// ALU top: combinational datapath followed by an enable-gated result register.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_en,
   input  logic [SEL_W-1:0]  I_alusel,
   input  logic [DATA_W-1:0] I_data1,
   input  logic [DATA_W-1:0] I_data2,
   output logic [DATA_W-1:0] O_data
);

   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] data_q;

   alu_comb #(
      .DATA_W (DATA_W)
   ) u_alu_comb (
      .alusel_i (I_alusel),
      .data1_i  (I_data1),
      .data2_i  (I_data2),
      .result_o (result)
   );

   always_comb begin
      data_d = data_q;
      if (I_en) begin
         data_d = result;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign O_data = data_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors, hold/reset cases and random ops vs a model.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [3:0]  alusel;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [31:0] o_data;

   int n_checks = 0;
   int n_fails  = 0;

   alu_core #(
      .DATA_W (32)
   ) dut (
      .I_clk    (clk),
      .I_rst_n  (rst_n),
      .I_en     (en),
      .I_alusel (alusel),
      .I_data1  (data1),
      .I_data2  (data2),
      .O_data   (o_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference built from arithmetic: shifts as multiply/divide by powers of two.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] pow;
      logic [63:0] prod;
      logic [31:0] r;
      pow = 64'd1 << b[4:0];
      r   = 32'd0;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a + (~b) + 32'd1;
         ALU_SLL:  begin prod = {32'd0, a} * pow; r = prod[31:0]; end
         ALU_SRL:  r = 32'({32'd0, a} / pow);
         ALU_SRA:  r = a[31] ? ~(32'({32'd0, ~a} / pow)) : 32'({32'd0, a} / pow);
         ALU_SLT:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: r = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
         ALU_XOR:  r = a ^ b;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_LUI:  r = b;
         default:  r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] exp);
      n_checks++;
      assert (o_data === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, o_data, exp);
      end
   endtask

   // Drive at negedge, sample 1 time unit after the loading edge.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      @(negedge clk);
      en     = 1'b1;
      alusel = op;
      data1  = a;
      data2  = b;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  unused_ops [5];

      rst_n  = 1'b1;
      en     = 1'b1;
      alusel = ALU_ADD;
      data1  = 32'd3;
      data2  = 32'd1;
      #1 rst_n = 1'b0;
      #1 check("reset_async", 32'd0);
      repeat (2) @(posedge clk);
      #1 check("reset_held_en1", 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("a3b1_add",  ALU_ADD,  32'd3, 32'd1, 32'd4);
      run_op("a3b1_sub",  ALU_SUB,  32'd3, 32'd1, 32'd2);
      run_op("a3b1_sll",  ALU_SLL,  32'd3, 32'd1, 32'd6);
      run_op("a3b1_slt",  ALU_SLT,  32'd3, 32'd1, 32'd0);
      run_op("a3b1_sltu", ALU_SLTU, 32'd3, 32'd1, 32'd0);
      run_op("a3b1_xor",  ALU_XOR,  32'd3, 32'd1, 32'd2);
      run_op("a3b1_srl",  ALU_SRL,  32'd3, 32'd1, 32'd1);
      run_op("a3b1_sra",  ALU_SRA,  32'd3, 32'd1, 32'd1);
      run_op("a3b1_or",   ALU_OR,   32'd3, 32'd1, 32'd3);
      run_op("a3b1_and",  ALU_AND,  32'd3, 32'd1, 32'd1);
      run_op("a3b1_lui",  ALU_LUI,  32'd3, 32'd1, 32'd1);

      run_op("am3b1_add",  ALU_ADD,  32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFE);
      run_op("am3b1_sub",  ALU_SUB,  32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFC);
      run_op("am3b1_slt",  ALU_SLT,  32'hFFFF_FFFD, 32'd1, 32'd1);
      run_op("am3b1_sltu", ALU_SLTU, 32'hFFFF_FFFD, 32'd1, 32'd0);
      run_op("am3b1_srl",  ALU_SRL,  32'hFFFF_FFFD, 32'd1, 32'h7FFF_FFFE);
      run_op("am3b1_sra",  ALU_SRA,  32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFE);
      run_op("am3b1_and",  ALU_AND,  32'hFFFF_FFFD, 32'd1, 32'd1);
      run_op("am3b1_or",   ALU_OR,   32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFD);

      run_op("a1bm3_slt",  ALU_SLT,  32'd1, 32'hFFFF_FFFD, 32'd0);
      run_op("a1bm3_sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFD, 32'd1);
      run_op("a1bm3_sll",  ALU_SLL,  32'd1, 32'hFFFF_FFFD, 32'h2000_0000);
      run_op("a1bm3_lui",  ALU_LUI,  32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD);

      // Shift amount is B[4:0] = 31, so a logical shift of all-ones leaves a single 1.
      run_op("am1bm1_sub",  ALU_SUB,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      run_op("am1bm1_slt",  ALU_SLT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      run_op("am1bm1_sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      run_op("am1bm1_xor",  ALU_XOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
      run_op("am1bm1_sra",  ALU_SRA,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("am1bm1_srl",  ALU_SRL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

      run_op("a7b2_add", ALU_ADD, 32'd7, 32'd2, 32'd9);
      run_op("a7b2_sub", ALU_SUB, 32'd7, 32'd2, 32'd5);
      run_op("a7b2_sll", ALU_SLL, 32'd7, 32'd2, 32'd28);
      run_op("a7b2_srl", ALU_SRL, 32'd7, 32'd2, 32'd1);
      run_op("a7b2_sra", ALU_SRA, 32'd7, 32'd2, 32'd1);
      run_op("a7b2_and", ALU_AND, 32'd7, 32'd2, 32'd2);
      run_op("a7b2_or",  ALU_OR,  32'd7, 32'd2, 32'd7);
      run_op("a7b2_xor", ALU_XOR, 32'd7, 32'd2, 32'd5);

      run_op("shamt_upper_ignored", ALU_SLL, 32'd1, 32'hFFFF_FFE4, 32'h0000_0010);

      // Hold: load 4, then disable and change inputs.
      run_op("hold_load", ALU_ADD, 32'd3, 32'd1, 32'd4);
      @(negedge clk);
      en     = 1'b0;
      alusel = ALU_XOR;
      data1  = 32'hDEAD_BEEF;
      data2  = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1 check("hold_en0", 32'd4);

      // Reset between edges discards the pending result.
      run_op("pre_reset_load", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
      @(negedge clk);
      en     = 1'b1;
      alusel = ALU_ADD;
      data1  = 32'd3;
      data2  = 32'd1;
      #2 rst_n = 1'b0;
      #1 check("reset_mid_cycle", 32'd0);
      #1 rst_n = 1'b1;
      en = 1'b0;
      @(posedge clk);
      #1 check("reset_pending_discarded", 32'd0);

      unused_ops = '{4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
      foreach (unused_ops[i]) begin
         run_op($sformatf("unused_%b", unused_ops[i]), unused_ops[i], $urandom, $urandom, 32'd0);
      end

      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if (i % 4 == 0) b = b & 32'h0000_001F;
         run_op($sformatf("rand_%0d_op%b", i, op), op, a, b, ref_alu(op, a, b));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
